// File: rtl/output_sr_arbiter.sv
// -----------------------------------------------------------------------------
// output_sr_arbiter
//   Round-robin arbiter/sequencer that shares one output_sr byte serializer
//   between N_REQ requesters. Each request carries one byte; the winner's byte
//   is loaded into the serializer, the requester is acked in the load cycle,
//   and the arbiter waits for the serializer's busy flag to clear before the
//   next grant.
//
//   Optional build macro: OUTPUT_SR_ARB_TAG_EN
//     When defined, every grant first sends a tag byte {4'hA, grant id} and
//     then the data byte; the ack pulses only with the data byte.
//
// Ports
//   i_clk       system clock, rising edge
//   i_rst       synchronous active-high reset
//   i_req       per-requester request (held with stable data until acked)
//   i_data      requester k byte at [8k+7:8k]
//   o_ack       one-cycle one-hot accept pulse
//   o_sr_load   load pulse to output_sr
//   o_sr_data   byte to output_sr, valid while o_sr_load=1
//   i_sr_busy   busy flag from output_sr
//   o_grant_id  current owner id, valid while o_busy=1
//   o_busy      high whenever the arbiter is not idle
// -----------------------------------------------------------------------------
module output_sr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [N_REQ-1:0]   i_req,
  input  logic [N_REQ*8-1:0] i_data,
  output logic [N_REQ-1:0]   o_ack,
  output logic               o_sr_load,
  output logic [7:0]         o_sr_data,
  input  logic               i_sr_busy,
  output logic [ID_W-1:0]    o_grant_id,
  output logic               o_busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  localparam logic [N_REQ-1:0] ONE_HOT_0 = {{(N_REQ-1){1'b0}}, 1'b1};

  logic [1:0]       state_reg;
  logic [ID_W-1:0]  last_reg;
  logic [ID_W-1:0]  grant_id_reg;
  logic [N_REQ-1:0] ack_reg;
  logic             sr_load_reg;
  logic [7:0]       sr_data_reg;
  logic             busy_reg;
`ifdef OUTPUT_SR_ARB_TAG_EN
  logic [7:0]       byte_reg;   // data byte held while the tag byte drains
  logic             phase_reg;  // 0 = tag byte in flight, 1 = data byte
`endif

  // Unpack the flat data bus into one byte per requester.
  logic [7:0] req_byte [N_REQ];
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign req_byte[gi] = i_data[8*gi +: 8];
    end
  endgenerate

  // Round-robin winner: first set request searching upward from last+1,
  // wrapping, so the previous owner has lowest priority.
  logic             win_found;
  logic [ID_W-1:0]  win_id;
  logic [7:0]       win_byte;
  logic [N_REQ-1:0] win_onehot;
  int               rr_idx;

  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    win_byte  = '0;
    rr_idx    = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      rr_idx = (int'(last_reg) + i) % N_REQ;
      if (!win_found && i_req[rr_idx]) begin
        win_found = 1'b1;
        win_id    = ID_W'(rr_idx);
        win_byte  = req_byte[rr_idx];
      end
    end
    win_onehot = ONE_HOT_0 << win_id;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg    <= ST_IDLE;
      last_reg     <= ID_W'(N_REQ - 1);
      grant_id_reg <= '0;
      ack_reg      <= '0;
      sr_load_reg  <= 1'b0;
      sr_data_reg  <= '0;
      busy_reg     <= 1'b0;
`ifdef OUTPUT_SR_ARB_TAG_EN
      byte_reg     <= '0;
      phase_reg    <= 1'b0;
`endif
    end else begin
      // Ack and load are single-cycle pulses.
      ack_reg     <= '0;
      sr_load_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (win_found) begin
            grant_id_reg <= win_id;
            last_reg     <= win_id;
            busy_reg     <= 1'b1;
            sr_load_reg  <= 1'b1;
            state_reg    <= ST_LOAD;
`ifdef OUTPUT_SR_ARB_TAG_EN
            byte_reg     <= win_byte;
            sr_data_reg  <= 8'hA0 | 8'(win_id);
            phase_reg    <= 1'b0;
`else
            sr_data_reg  <= win_byte;
            ack_reg      <= win_onehot;
`endif
          end
        end
        ST_LOAD:  state_reg <= ST_HOLD;
        // HOLD ignores busy: the serializer's busy flag rises a cycle late.
        ST_HOLD:  state_reg <= ST_DRAIN;
        ST_DRAIN: begin
          if (!i_sr_busy) begin
`ifdef OUTPUT_SR_ARB_TAG_EN
            if (!phase_reg) begin
              // Tag done: send the data byte without passing through IDLE,
              // so busy and grant id stay constant for the whole grant.
              phase_reg   <= 1'b1;
              sr_load_reg <= 1'b1;
              sr_data_reg <= byte_reg;
              ack_reg     <= ONE_HOT_0 << grant_id_reg;
              state_reg   <= ST_LOAD;
            end else begin
              busy_reg  <= 1'b0;
              state_reg <= ST_IDLE;
            end
`else
            busy_reg  <= 1'b0;
            state_reg <= ST_IDLE;
`endif
          end
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_ack      = ack_reg;
  assign o_sr_load  = sr_load_reg;
  assign o_sr_data  = sr_data_reg;
  assign o_grant_id = grant_id_reg;
  assign o_busy     = busy_reg;

endmodule

// File: tb/tb_output_sr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_output_sr_arbiter
//   Directed bench for output_sr_arbiter with a small output_sr busy model.
//   Expected loads are queued when a request is issued; a monitor pops and
//   compares on every o_sr_load pulse.
// -----------------------------------------------------------------------------
module tb_output_sr_arbiter;

  localparam int N_REQ = 4;
  localparam int ID_W  = 2;

  logic               clk = 1'b0;
  logic               i_rst;
  logic [N_REQ-1:0]   i_req;
  logic [N_REQ*8-1:0] i_data;
  logic [N_REQ-1:0]   o_ack;
  logic               o_sr_load;
  logic [7:0]         o_sr_data;
  logic               i_sr_busy;
  logic [ID_W-1:0]    o_grant_id;
  logic               o_busy;

  output_sr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_req      (i_req),
    .i_data     (i_data),
    .o_ack      (o_ack),
    .o_sr_load  (o_sr_load),
    .o_sr_data  (o_sr_data),
    .i_sr_busy  (i_sr_busy),
    .o_grant_id (o_grant_id),
    .o_busy     (o_busy)
  );

  always #5 clk = ~clk;

  // Serializer model: busy for 8 cycles after each load.
  int busy_cnt;
  always @(posedge clk) begin
    if (i_rst)               busy_cnt <= 0;
    else if (o_sr_load)      busy_cnt <= 8;
    else if (busy_cnt != 0)  busy_cnt <= busy_cnt - 1;
  end
  assign i_sr_busy = (busy_cnt != 0);

  typedef struct packed {
    logic [3:0] id;
    logic [7:0] data;
    logic [3:0] ack;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Queue the load(s) one grant produces.
  task automatic push_grant(input int id, input logic [7:0] b);
    exp_t e;
`ifdef OUTPUT_SR_ARB_TAG_EN
    e.id = 4'(id); e.data = 8'hA0 | 8'(id); e.ack = 4'h0;
    exp_q.push_back(e);
`endif
    e.id = 4'(id); e.data = b; e.ack = 4'(1 << id);
    exp_q.push_back(e);
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!i_rst && o_sr_load) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL unexpected_load: got data %02h id %0d, expected none", o_sr_data, o_grant_id);
      end else begin
        e = exp_q.pop_front();
        $display("[TB] load id=%0d data=%02h ack=%b (expect id=%0d data=%02h ack=%b)",
                 o_grant_id, o_sr_data, o_ack, e.id, e.data, e.ack);
        check("load_data", 32'(o_sr_data), 32'(e.data));
        check("load_id", 32'(o_grant_id), 32'(e.id));
        check("load_ack", 32'(o_ack), 32'(e.ack));
        check("load_busy", 32'(o_busy), 32'd1);
        check("load_overlap_sr_busy", 32'(i_sr_busy), 32'd0);
      end
    end
    if (o_ack != '0) check("ack_needs_load", 32'(o_sr_load), 32'd1);
  end

  task automatic do_reset;
    i_rst = 1'b1;
    i_req = '0;
    repeat (2) @(negedge clk);
    i_rst = 1'b0;
  endtask

  task automatic wait_ack(input int k);
    int n = 0;
    @(negedge clk);
    while (!o_ack[k] && n < 400) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("ack_seen_%0d", k), 32'(o_ack[k]), 32'd1);
  endtask

  task automatic wait_sr_busy;
    int n = 0;
    while (!i_sr_busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("sr_busy_rise", 32'(i_sr_busy), 32'd1);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (o_busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({name, "_busy_fall"}, 32'(o_busy), 32'd0);
    check({name, "_sr_idle"}, 32'(i_sr_busy), 32'd0);
    check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int n;
    bit saw_idle;
    i_rst  = 1'b1;
    i_req  = '0;
    i_data = '0;
    repeat (3) @(negedge clk);

    // Reset values.
    check("rst_ack", 32'(o_ack), 32'd0);
    check("rst_load", 32'(o_sr_load), 32'd0);
    check("rst_data", 32'(o_sr_data), 32'd0);
    check("rst_grant", 32'(o_grant_id), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    i_rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_no_req_busy", 32'(o_busy), 32'd0);

    // Single request.
    do_reset();
    push_grant(0, 8'h5A);
    i_data[7:0] = 8'h5A;
    i_req = 4'b0001;
    wait_ack(0);
    i_req[0] = 1'b0;
    wait_idle("single");

    // Simultaneous requests 1 and 2 from reset.
    do_reset();
    push_grant(1, 8'h11);
    push_grant(2, 8'h22);
    i_data = {8'h00, 8'h22, 8'h11, 8'h00};
    i_req = 4'b0110;
    wait_ack(1);
    i_req[1] = 1'b0;
    wait_ack(2);
    i_req[2] = 1'b0;
    wait_idle("simul");

    // Fairness: all four continuously requesting.
    do_reset();
    push_grant(0, 8'h01);
    push_grant(1, 8'h80);
    push_grant(2, 8'h00);
    push_grant(3, 8'hFF);
    push_grant(0, 8'h01);
    push_grant(1, 8'h80);
    i_data = {8'hFF, 8'h00, 8'h80, 8'h01};
    i_req = 4'b1111;
    cnt = 0;
    n = 0;
    while (cnt < 6 && n < 2000) begin
      @(negedge clk);
      if (o_ack != '0) cnt++;
      n++;
    end
    i_req = '0;
    check("fair_ack_count", 32'(cnt), 32'd6);
    wait_idle("fair");

    // Late arrival of requester 3 during DRAIN.
    do_reset();
    push_grant(0, 8'h33);
    i_data = {8'hC3, 8'h00, 8'h00, 8'h33};
    i_req = 4'b0001;
    wait_ack(0);
    i_req[0] = 1'b0;
    wait_sr_busy();
    push_grant(3, 8'hC3);
    i_req[3] = 1'b1;
    saw_idle = 1'b0;
    n = 0;
    while (!o_ack[3] && n < 400) begin
      @(negedge clk);
      if (!o_busy) saw_idle = 1'b1;
      n++;
    end
    check("late_ack_seen", 32'(o_ack[3]), 32'd1);
    check("late_idle_before_ack", 32'(saw_idle), 32'd1);
    i_req[3] = 1'b0;
    wait_idle("late");

    // Reset mid-DRAIN with requesters 0 and 2 pending.
    do_reset();
    push_grant(1, 8'h3C);
    i_data = {8'h00, 8'hF0, 8'h3C, 8'h0F};
    i_req = 4'b0010;
    wait_ack(1);
    i_req = 4'b0101;
    wait_sr_busy();
    i_rst = 1'b1;
    @(negedge clk);
    check("midrst_ack", 32'(o_ack), 32'd0);
    check("midrst_load", 32'(o_sr_load), 32'd0);
    check("midrst_data", 32'(o_sr_data), 32'd0);
    check("midrst_grant", 32'(o_grant_id), 32'd0);
    check("midrst_busy", 32'(o_busy), 32'd0);
    push_grant(0, 8'h0F);
    push_grant(2, 8'hF0);
    i_rst = 1'b0;
    wait_ack(0);
    i_req[0] = 1'b0;
    wait_ack(2);
    i_req[2] = 1'b0;
    wait_idle("midrst");

    // Requester 2 with 0xAA (tag byte 0xA2 first when tagging is built in).
    do_reset();
    push_grant(2, 8'hAA);
    i_data = {8'h00, 8'hAA, 8'h00, 8'h00};
    i_req = 4'b0100;
    wait_ack(2);
    i_req[2] = 1'b0;
    wait_idle("tag");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
